// File: rtl/udp_rx_pkt_buffer.sv
// Receive packet buffer: stores UDP payloads in a byte RAM and commits whole good packets.
// Optional feature macro: UDP_RX_DROP_CNT_EN enables the saturating drop counter.
module udp_rx_pkt_buffer #(
    parameter int ADDR_W      = 11,
    parameter int MAX_LEN     = 1472,
    parameter int LEN_DEPTH_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_sof,
    input  logic        rx_eof,
    input  logic        rx_err,
    output logic        rx_trig,
    output logic        pkt_avail,
    output logic [10:0] pkt_len,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        rd_last,
    output logic [15:0] drop_cnt
);

    localparam int LEN_W = 11;

    typedef logic [ADDR_W:0]      ptr_t;
    typedef logic [LEN_W-1:0]     len_t;
    typedef logic [LEN_DEPTH_W:0] lf_ptr_t;
    typedef enum logic [1:0] {IDLE, RECV, DROP} wr_state_e;

    localparam ptr_t    RAM_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam lf_ptr_t LF_DEPTH  = {1'b1, {LEN_DEPTH_W{1'b0}}};
    localparam len_t    MAX_LEN_L = len_t'(MAX_LEN);

    logic [7:0] ram    [2**ADDR_W];
    len_t       lf_mem [2**LEN_DEPTH_W];

    wr_state_e state, state_n;
    ptr_t      wr_ptr, wr_ptr_n;
    ptr_t      cmt_ptr, cmt_ptr_n;
    ptr_t      rd_ptr;
    len_t      cur_len, cur_len_n;
    len_t      rd_cnt;
    lf_ptr_t   lf_wr, lf_rd;

    ptr_t      beat_ptr;
    ptr_t      beat_used;
    len_t      beat_len;
    logic      takes_beat;
    logic      has_room;
    logic      len_ok;
    logic      lf_full;
    logic      lf_push;
    logic      lf_pop;
    logic      ram_we;
    logic      abort_drop;
    logic      fail_drop;
    logic      rd_fire;
    logic      rd_is_last;

    // A new sof always restarts from the last committed address; otherwise continue the packet.
    assign beat_ptr   = rx_sof ? cmt_ptr : wr_ptr;
    assign beat_len   = rx_sof ? len_t'(1) : cur_len + 1'b1;
    assign beat_used  = beat_ptr - rd_ptr;
    assign has_room   = (beat_used != RAM_DEPTH);
    assign len_ok     = rx_sof || (cur_len != MAX_LEN_L);
    assign takes_beat = rx_valid && (rx_sof || (state == RECV));
    assign lf_full    = ((lf_wr - lf_rd) == LF_DEPTH);

    assign pkt_avail  = (lf_wr != lf_rd);
    assign pkt_len    = pkt_avail ? lf_mem[lf_rd[LEN_DEPTH_W-1:0]] : '0;
    assign rd_fire    = rd_en && pkt_avail;
    assign rd_is_last = (rd_cnt == pkt_len - 1'b1);
    assign lf_pop     = rd_fire && rd_is_last;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_n    = state;
        wr_ptr_n   = wr_ptr;
        cmt_ptr_n  = cmt_ptr;
        cur_len_n  = cur_len;
        ram_we     = 1'b0;
        lf_push    = 1'b0;
        fail_drop  = 1'b0;
        abort_drop = rx_valid && rx_sof && (state != IDLE);

        if (takes_beat) begin
            if (has_room && len_ok) begin
                ram_we = 1'b1;
                if (rx_eof) begin
                    state_n = IDLE;
                    if (!rx_err && !lf_full) begin
                        lf_push   = 1'b1;
                        wr_ptr_n  = beat_ptr + 1'b1;
                        cmt_ptr_n = beat_ptr + 1'b1;
                    end else begin
                        fail_drop = 1'b1;
                        wr_ptr_n  = cmt_ptr;
                    end
                end else begin
                    state_n   = RECV;
                    wr_ptr_n  = beat_ptr + 1'b1;
                    cur_len_n = beat_len;
                end
            end else begin
                // Out of room or over length: roll back and discard the rest.
                wr_ptr_n = cmt_ptr;
                if (rx_eof) begin
                    state_n   = IDLE;
                    fail_drop = 1'b1;
                end else begin
                    state_n = DROP;
                end
            end
        end else if (rx_valid && rx_eof && (state == DROP)) begin
            state_n   = IDLE;
            fail_drop = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            cmt_ptr <= '0;
            cur_len <= '0;
            lf_wr   <= '0;
            rx_trig <= 1'b0;
        end else begin
            state   <= state_n;
            wr_ptr  <= wr_ptr_n;
            cmt_ptr <= cmt_ptr_n;
            cur_len <= cur_len_n;
            rx_trig <= lf_push;
            if (lf_push) begin
                lf_wr <= lf_wr + 1'b1;
            end
        end
    end

    // NOTE: storage arrays carry no reset; pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[beat_ptr[ADDR_W-1:0]] <= rx_data;
        end
        if (lf_push) begin
            lf_mem[lf_wr[LEN_DEPTH_W-1:0]] <= beat_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            rd_cnt  <= '0;
            lf_rd   <= '0;
            rd_data <= '0;
            rd_last <= 1'b0;
        end else begin
            rd_last <= rd_fire && rd_is_last;
            if (rd_fire) begin
                rd_data <= ram[rd_ptr[ADDR_W-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
                rd_cnt  <= rd_is_last ? '0 : rd_cnt + 1'b1;
            end
            if (lf_pop) begin
                lf_rd <= lf_rd + 1'b1;
            end
        end
    end

`ifdef UDP_RX_DROP_CNT_EN
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    // An aborting sof can fail its own one-byte packet too, so up to two drops per cycle.
    assign drop_inc = {1'b0, abort_drop} + {1'b0, fail_drop};
    assign drop_sum = {1'b0, drop_cnt} + {15'd0, drop_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`else
    logic unused_drop;

    assign unused_drop = abort_drop ^ fail_drop;
    assign drop_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_udp_rx_pkt_buffer.sv
// Directed self-checking bench for udp_rx_pkt_buffer: commit, drop, overflow, FIFO full, wrap.
module tb_udp_rx_pkt_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_sof = 1'b0;
    logic        rx_eof = 1'b0;
    logic        rx_err = 1'b0;
    logic        rx_trig;
    logic        pkt_avail;
    logic [10:0] pkt_len;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_last;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int trig_cnt = 0;
    int t0;
    logic [8:0] exp_q[$];

    udp_rx_pkt_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_sof    (rx_sof),
        .rx_eof    (rx_eof),
        .rx_err    (rx_err),
        .rx_trig   (rx_trig),
        .pkt_avail (pkt_avail),
        .pkt_len   (pkt_len),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_trig) trig_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_drop(input int n);
`ifdef UDP_RX_DROP_CNT_EN
        return 16'(n);
`else
        return 16'd0 + 16'(n * 0);
`endif
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rd_en    = 1'b0;
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic send_pkt(input int len, input logic [7:0] seed, input logic err,
                            input logic with_eof);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = seed + 8'(i);
            rx_sof   = (i == 0);
            rx_eof   = with_eof && (i == len - 1);
            rx_err   = err && rx_eof;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_eof   = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic expect_pkt(input int len, input logic [7:0] seed);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = seed + 8'(i);
            exp_q.push_back({(i == len - 1), b});
        end
    endtask

    // Continuous rd_en for n cycles; each byte checked on the following falling edge.
    task automatic read_n(input int n);
        logic [8:0] e;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (exp_q.size() == 0) begin
                    check("exp underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd byte", {23'd0, rd_last, rd_data}, {23'd0, e});
                end
            end
            rd_en = (i < n);
        end
    endtask

    initial begin
        idle(3);
        check("rst rx_trig", rx_trig, 0);
        check("rst pkt_avail", pkt_avail, 0);
        check("rst pkt_len", pkt_len, 0);
        check("rst rd_data", rd_data, 0);
        check("rst rd_last", rd_last, 0);
        check("rst drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        idle(1);

        // Single 100-byte packet
        t0 = trig_cnt;
        send_pkt(100, 8'h00, 1'b0, 1'b1);
        idle(2);
        check("single trig", trig_cnt - t0, 1);
        check("single avail", pkt_avail, 1);
        check("single len", pkt_len, 100);
        expect_pkt(100, 8'h00);
        read_n(100);
        check("single empty", pkt_avail, 0);
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("ignored rd", {23'd0, rd_last, rd_data}, {23'd0, 1'b0, 8'h63});

        // Error packet then good packet
        do_reset();
        send_pkt(64, 8'hA0, 1'b1, 1'b1);
        send_pkt(10, 8'h40, 1'b0, 1'b1);
        idle(2);
        check("err drop", drop_cnt, exp_drop(1));
        check("err len", pkt_len, 10);
        expect_pkt(10, 8'h40);
        read_n(10);
        check("err empty", pkt_avail, 0);

        // Oversize then maximum length
        do_reset();
        t0 = trig_cnt;
        send_pkt(1473, 8'h00, 1'b0, 1'b1);
        idle(2);
        check("over drop", drop_cnt, exp_drop(1));
        check("over avail", pkt_avail, 0);
        check("over trig", trig_cnt - t0, 0);
        send_pkt(1472, 8'h05, 1'b0, 1'b1);
        idle(2);
        check("max len", pkt_len, 1472);
        expect_pkt(1472, 8'h05);
        read_n(1472);

        // RAM overflow
        do_reset();
        t0 = trig_cnt;
        send_pkt(1400, 8'h01, 1'b0, 1'b1);
        send_pkt(1000, 8'h02, 1'b0, 1'b1);
        idle(2);
        check("ovf trig", trig_cnt - t0, 1);
        check("ovf drop", drop_cnt, exp_drop(1));
        check("ovf len", pkt_len, 1400);
        expect_pkt(1400, 8'h01);
        read_n(1400);
        check("ovf empty", pkt_avail, 0);
        send_pkt(1000, 8'h03, 1'b0, 1'b1);
        idle(2);
        check("ovf retry len", pkt_len, 1000);
        expect_pkt(1000, 8'h03);
        read_n(1000);

        // Length FIFO full, then back-to-back reads across packets
        do_reset();
        t0 = trig_cnt;
        for (int k = 0; k < 9; k++) send_pkt(4, 8'(k * 16), 1'b0, 1'b1);
        idle(2);
        check("full trig", trig_cnt - t0, 8);
        check("full drop", drop_cnt, exp_drop(1));
        check("full len", pkt_len, 4);
        for (int k = 0; k < 8; k++) expect_pkt(4, 8'(k * 16));
        read_n(32);
        check("full empty", pkt_avail, 0);

        // One-byte packet and mid-packet sof
        do_reset();
        send_pkt(1, 8'h77, 1'b0, 1'b1);
        idle(2);
        check("one len", pkt_len, 1);
        expect_pkt(1, 8'h77);
        read_n(1);
        send_pkt(20, 8'h10, 1'b0, 1'b0);
        send_pkt(5, 8'h90, 1'b0, 1'b1);
        idle(2);
        check("sof drop", drop_cnt, exp_drop(1));
        check("sof len", pkt_len, 5);
        expect_pkt(5, 8'h90);
        read_n(5);
        check("sof empty", pkt_avail, 0);

        // Reset with committed and partial data buffered
        send_pkt(50, 8'h33, 1'b0, 1'b1);
        send_pkt(30, 8'h55, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        idle(1);
        check("midrst avail", pkt_avail, 0);
        check("midrst len", pkt_len, 0);
        check("midrst drop", drop_cnt, 0);
        rst_n = 1'b1;
        idle(1);
        send_pkt(3, 8'hC0, 1'b0, 1'b1);
        idle(2);
        check("postrst len", pkt_len, 3);
        expect_pkt(3, 8'hC0);
        read_n(3);

        // Pointer wrap: 10 KB streamed through
        do_reset();
        t0 = trig_cnt;
        for (int k = 0; k < 10; k++) begin
            send_pkt(1024, 8'(k * 7), 1'b0, 1'b1);
            idle(2);
            check("wrap len", pkt_len, 1024);
            expect_pkt(1024, 8'(k * 7));
            read_n(1024);
        end
        check("wrap trig", trig_cnt - t0, 10);
        check("wrap drop", drop_cnt, 0);
        check("wrap empty", pkt_avail, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/udp_rx_pkt_buffer.md
# udp_rx_pkt_buffer

Receive-side packet buffer for the UDP path, the counterpart of the transmit FIFO/trigger logic. It accepts the byte stream delivered by the UDP receive engine, stores each datagram payload in an internal byte RAM, and commits it only when it completes error-free. It then presents complete packets, with their length, to the application read port. Bad, oversized or overflowing packets are rolled back and counted, so the application only ever sees whole, good packets.

## Interface
- ADDR_W, 11: byte RAM address width; capacity 2^ADDR_W = 2048 bytes.
- MAX_LEN, 1472: largest accepted payload in bytes.
- LEN_DEPTH_W, 3: length-FIFO address width; up to 8 committed packets.
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  rx_data beat valid.
- rx_data  in  8  payload byte.
- rx_sof  in  1  first byte of packet; qualified by rx_valid.
- rx_eof  in  1  last byte of packet; qualified by rx_valid; may coincide with rx_sof.
- rx_err  in  1  packet bad; sampled only on the eof beat.
- rx_trig  out  1  one-cycle pulse when a packet commits.
- pkt_avail  out  1  at least one committed packet is buffered.
- pkt_len  out  11  length of the head packet; valid while pkt_avail.
- rd_en  in  1  read one byte of the head packet.
- rd_data  out  8  byte read; valid one cycle after rd_en.
- rd_last  out  1  rd_data is the last byte of its packet.
- drop_cnt  out  16  saturating count of dropped packets.

## Operation
- Pointers: wr_ptr, cmt_ptr and rd_ptr are each ADDR_W+1 bits and wrap modulo 2^(ADDR_W+1).
- Free space is 2^ADDR_W − (wr_ptr − rd_ptr).
- Write FSM states: IDLE, RECV, DROP.
  - IDLE: on rx_valid&rx_sof, write the byte, set cur_len=1, go to RECV. If rx_eof is also set, evaluate the commit in the same cycle. Non-sof beats are ignored.
  - RECV: each valid beat writes a byte and increments cur_len.
  - RECV, entry to DROP: a beat arriving with free space = 0, or with cur_len = MAX_LEN, is not written. Set wr_ptr ← cmt_ptr and go to DROP. If that beat is also eof, go to IDLE instead and count the drop.
  - DROP: discard beats until eof, then count the drop and go to IDLE.
- Commit, on the eof beat:
  - Condition: rx_err=0, cur_len ≤ MAX_LEN and the length FIFO is not full.
  - Action: push cur_len, cmt_ptr ← wr_ptr+1 (the address after the eof byte), pulse rx_trig, return to IDLE.
  - If any condition fails: wr_ptr ← cmt_ptr, drop_cnt increments, return to IDLE.
- rx_sof while in RECV: abort the current packet as a drop (rollback, count), then start the new packet with this byte.
- Read side:
  - pkt_avail = length FIFO not empty. pkt_len = length-FIFO head.
  - rd_en while pkt_avail reads RAM[rd_ptr], increments rd_ptr and increments rd_cnt.
  - When rd_cnt reaches pkt_len − 1 the read is the last byte. rd_last is asserted with that byte one cycle later, rd_cnt clears, and the length FIFO is popped in the same cycle as the read.
  - rd_en while !pkt_avail is ignored: no pointer change, rd_data holds, rd_last=0.
  - Back-to-back rd_en across a packet boundary continues into the next packet if one is committed.
- The reader can never overtake the writer, because rd_ptr only advances through committed bytes.

## Timing
- Reset values: rx_trig=0, pkt_avail=0, pkt_len=0, rd_data=0, rd_last=0, drop_cnt=0. All pointers are 0 and the FSM is in IDLE.
- rx_trig is asserted on the cycle after the committing eof beat.
- pkt_avail rises on that same cycle.
- Read latency: 1 cycle from rd_en to rd_data and rd_last.
- Simultaneous commit and pop: the FIFO count is unchanged and pkt_avail stays 1. pkt_len updates on the cycle after the pop.
- Write and read in the same cycle are independent. Free space uses the registered rd_ptr, so a byte freed in cycle N is usable in cycle N+1.
- drop_cnt increments on the cycle after the drop decision and saturates at 16'hFFFF.
- Reset mid-packet: all buffered and partial data is discarded.

## Configuration
- UDP_RX_DROP_CNT_EN defined: drop_cnt is implemented as specified.
- UDP_RX_DROP_CNT_EN undefined: the counter logic is removed and drop_cnt is tied to 16'd0. Drop behaviour itself is unchanged.

## Test plan
- Single packet: 100 bytes 0x00..0x63 with rx_err=0 → rx_trig pulse, pkt_avail=1, pkt_len=100. 100 rd_en reads return 0x00..0x63 with rd_last only on 0x63; pkt_avail=0 afterwards.
- Error packet: 64 bytes with rx_err=1 on eof, followed by a 10-byte good packet → drop_cnt=1, pkt_len=10, and the reader sees only the 10 bytes.
- Oversize: 1473-byte packet → dropped, drop_cnt=1, pkt_avail=0. A following 1472-byte packet commits with pkt_len=1472.
- Overflow: no reads during 1400 and 1000-byte packets → the first commits and the second drops. After the first packet is read out, a 1000-byte packet commits.
- Length FIFO full: nine 4-byte packets with no reads → eight commit and the ninth drops, drop_cnt=1.
- Boundary stress: a 1-byte packet (sof=eof) commits with pkt_len=1 and rd_last on its only byte. A sof in mid-packet drops the old packet and keeps the new one. Continuous rd_en across back-to-back packets yields no gap and the correct rd_last positions. Pointer wrap is checked by streaming 10 KB.
